// File: rtl/javk_bus_pkg.sv
// Shared encodings and sizes for the JAVK external bus sequencer.
package javk_bus_pkg;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned WAIT_MAX   = 15;
    localparam int unsigned CNT_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

endpackage

// File: rtl/javk_bus_arb.sv
// Grant selection between fetch and load/store; LS wins unless it won last time.
module javk_bus_arb
    import javk_bus_pkg::*;
(
    input  logic   if_req,
    input  logic   ls_req,
    input  logic   last_ls,
    output logic   grant_valid,
    output owner_t grant_owner
);

    assign grant_valid = if_req | ls_req;

    // Alternate under contention, single requester always wins
    always_comb begin
        grant_owner = OWN_IF;
        if (ls_req && !(if_req && last_ls)) begin
            grant_owner = OWN_LS;
        end
    end

endmodule

// File: rtl/javk_bus_ctrl.sv
// Serializes fetch and load/store requests onto the single external memory bus
// with programmable wait states and a turnaround cycle after every access.
module javk_bus_ctrl
    import javk_bus_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_done,
    output logic [DATA_W-1:0] ls_rdata,
    output logic [ADDR_W-1:0] addrbus,
    output logic              rw,
    output logic [DATA_W-1:0] dout,
    input  logic [DATA_W-1:0] din,
    output logic              busy
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_STATES);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    owner_t            owner, owner_nxt;
    logic              last_ls, last_ls_nxt;
    logic [ADDR_W-1:0] addrbus_nxt;
    logic              rw_nxt;
    logic [DATA_W-1:0] dout_nxt;
    logic              if_done_nxt, ls_done_nxt;
    logic [DATA_W-1:0] if_rdata_nxt, ls_rdata_nxt;
    logic              busy_nxt;
    logic              grant_valid;
    owner_t            grant_owner;

    javk_bus_arb u_arb (
        .if_req      (if_req),
        .ls_req      (ls_req),
        .last_ls     (last_ls),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    // State and registered bus/handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            owner    <= OWN_IF;
            last_ls  <= 1'b0;
            addrbus  <= '0;
            rw       <= 1'b0;
            dout     <= '0;
            if_done  <= 1'b0;
            ls_done  <= 1'b0;
            if_rdata <= '0;
            ls_rdata <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            owner    <= owner_nxt;
            last_ls  <= last_ls_nxt;
            addrbus  <= addrbus_nxt;
            rw       <= rw_nxt;
            dout     <= dout_nxt;
            if_done  <= if_done_nxt;
            ls_done  <= ls_done_nxt;
            if_rdata <= if_rdata_nxt;
            ls_rdata <= ls_rdata_nxt;
            busy     <= busy_nxt;
        end
    end

    // Next-state and next-output logic; addrbus itself is the latched address
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        owner_nxt    = owner;
        last_ls_nxt  = last_ls;
        addrbus_nxt  = addrbus;
        rw_nxt       = rw;
        dout_nxt     = dout;
        if_done_nxt  = 1'b0;
        ls_done_nxt  = 1'b0;
        if_rdata_nxt = if_rdata;
        ls_rdata_nxt = ls_rdata;

        case (state)
            ST_IDLE: begin
                rw_nxt = 1'b0;
                if (grant_valid) begin
                    owner_nxt = grant_owner;
                    cnt_nxt   = CNT_LOAD;
                    state_nxt = ST_ACCESS;
                    if (grant_owner == OWN_LS) begin
                        addrbus_nxt = ls_addr;
                        rw_nxt      = ls_we;
                        if (ls_we) begin
                            dout_nxt = ls_wdata;
                        end
                    end else begin
                        addrbus_nxt = if_addr;
                    end
                end
            end
            ST_ACCESS: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
                    state_nxt = ST_RESP;
                    rw_nxt    = 1'b0;
                    if (owner == OWN_LS) begin
                        ls_done_nxt = 1'b1;
                        if (!rw) begin
                            ls_rdata_nxt = din;
                        end
                    end else begin
                        if_done_nxt  = 1'b1;
                        if_rdata_nxt = din;
                    end
                end
            end
            ST_RESP: begin
                rw_nxt      = 1'b0;
                last_ls_nxt = (owner == OWN_LS);
                state_nxt   = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
                rw_nxt    = 1'b0;
            end
        endcase

        busy_nxt = (state_nxt != ST_IDLE);
    end

endmodule

// File: tb/tb_javk_bus_ctrl.sv
// Scoreboard bench for javk_bus_ctrl: one instance with WAIT_STATES=1, one with 0.
module tb_javk_bus_ctrl;
    import javk_bus_pkg::*;

    typedef struct {
        bit          is_ls;
        logic [15:0] addr;
        logic [7:0]  rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // WAIT_STATES = 1 instance signals
    logic        if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0;
    logic [15:0] if_addr = '0, ls_addr = '0;
    logic [7:0]  ls_wdata = '0, din = '0;
    logic        if_done, ls_done, rw, busy;
    logic [7:0]  if_rdata, ls_rdata, dout;
    logic [15:0] addrbus;

    // WAIT_STATES = 0 instance signals
    logic        if_req_z = 1'b0, ls_req_z = 1'b0, ls_we_z = 1'b0;
    logic [15:0] if_addr_z = '0, ls_addr_z = '0;
    logic [7:0]  ls_wdata_z = '0, din_z = '0;
    logic        if_done_z, ls_done_z, rw_z, busy_z;
    logic [7:0]  if_rdata_z, ls_rdata_z, dout_z;
    logic [15:0] addrbus_z;

    javk_bus_ctrl #(.WAIT_STATES(1), .ADDR_W(16), .DATA_W(8)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_done(ls_done), .ls_rdata(ls_rdata),
        .addrbus(addrbus), .rw(rw), .dout(dout), .din(din), .busy(busy)
    );

    javk_bus_ctrl #(.WAIT_STATES(0), .ADDR_W(16), .DATA_W(8)) u_dut_z (
        .clk(clk), .rst(rst),
        .if_req(if_req_z), .if_addr(if_addr_z), .if_done(if_done_z), .if_rdata(if_rdata_z),
        .ls_req(ls_req_z), .ls_we(ls_we_z), .ls_addr(ls_addr_z), .ls_wdata(ls_wdata_z),
        .ls_done(ls_done_z), .ls_rdata(ls_rdata_z),
        .addrbus(addrbus_z), .rw(rw_z), .dout(dout_z), .din(din_z), .busy(busy_z)
    );

    exp_t sb[$];
    exp_t sb_z[$];
    exp_t mon_e, mon_ez;
    int   n_chk = 0;
    int   n_err = 0;
    logic [7:0] ls_model = '0, if_model = '0;
    logic [7:0] ls_model_z = '0, if_model_z = '0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor for the WAIT_STATES=1 instance: pop and compare on every done
    always @(negedge clk) begin
        if (!rst && (if_done || ls_done)) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_done: if_done=%0b ls_done=%0b with empty scoreboard", if_done, ls_done);
            end else begin
                mon_e = sb.pop_front();
                check("done_owner", 32'(ls_done), 32'(mon_e.is_ls));
                check("done_excl", 32'(if_done & ls_done), 32'd0);
                check("resp_addr", 32'(addrbus), 32'(mon_e.addr));
                check("resp_rw", 32'(rw), 32'd0);
                if (mon_e.is_ls) check("ls_rdata", 32'(ls_rdata), 32'(mon_e.rdata));
                else             check("if_rdata", 32'(if_rdata), 32'(mon_e.rdata));
            end
        end
    end

    // Monitor for the WAIT_STATES=0 instance
    always @(negedge clk) begin
        if (!rst && (if_done_z || ls_done_z)) begin
            if (sb_z.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_done_z: if_done=%0b ls_done=%0b with empty scoreboard", if_done_z, ls_done_z);
            end else begin
                mon_ez = sb_z.pop_front();
                check("z_done_owner", 32'(ls_done_z), 32'(mon_ez.is_ls));
                check("z_resp_addr", 32'(addrbus_z), 32'(mon_ez.addr));
                check("z_resp_rw", 32'(rw_z), 32'd0);
                if (mon_ez.is_ls) check("z_ls_rdata", 32'(ls_rdata_z), 32'(mon_ez.rdata));
                else              check("z_if_rdata", 32'(if_rdata_z), 32'(mon_ez.rdata));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One access on the WAIT_STATES=1 instance; addr2 replaces the request address mid-access
    task automatic access(input bit is_ls, input bit we, input logic [15:0] addr,
                          input logic [15:0] addr2, input logic [7:0] wdata, input logic [7:0] dv);
        exp_t e;
        tick();
        din = dv;
        if (is_ls) begin
            ls_we = we; ls_addr = addr; ls_wdata = wdata; ls_req = 1'b1;
            if (!we) ls_model = dv;
            e.rdata = ls_model;
        end else begin
            if_addr = addr; if_req = 1'b1;
            if_model = dv;
            e.rdata = if_model;
        end
        e.is_ls = is_ls;
        e.addr  = addr;
        sb.push_back(e);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("busy", 32'(busy), 32'(k > 0));
            check("rw", 32'(rw), 32'((k == 1 || k == 2) && is_ls && we));
            if (k > 0) check("addrbus", 32'(addrbus), 32'(addr));
            if (k > 0 && k < 3 && is_ls && we) check("dout", 32'(dout), 32'(wdata));
            check("done_time", 32'(is_ls ? ls_done : if_done), 32'(k == 3));
            if (k == 1) begin
                if (is_ls) ls_addr = addr2;
                else       if_addr = addr2;
            end
        end
        tick();
        ls_req = 1'b0;
        if_req = 1'b0;
        @(negedge clk);
        check("done_pulse", 32'(ls_done | if_done), 32'd0);
        check("idle_after", 32'(busy), 32'd0);
    endtask

    // One access on the WAIT_STATES=0 instance
    task automatic access_z(input bit is_ls, input bit we, input logic [15:0] addr,
                            input logic [7:0] wdata, input logic [7:0] dv);
        exp_t e;
        tick();
        din_z = dv;
        if (is_ls) begin
            ls_we_z = we; ls_addr_z = addr; ls_wdata_z = wdata; ls_req_z = 1'b1;
            if (!we) ls_model_z = dv;
            e.rdata = ls_model_z;
        end else begin
            if_addr_z = addr; if_req_z = 1'b1;
            if_model_z = dv;
            e.rdata = if_model_z;
        end
        e.is_ls = is_ls;
        e.addr  = addr;
        sb_z.push_back(e);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("z_busy", 32'(busy_z), 32'(k == 1 || k == 2));
            check("z_rw", 32'(rw_z), 32'(k == 1 && is_ls && we));
            if (k > 0) check("z_addrbus", 32'(addrbus_z), 32'(addr));
            if (k == 1 && is_ls && we) check("z_dout", 32'(dout_z), 32'(wdata));
            check("z_done_time", 32'(is_ls ? ls_done_z : if_done_z), 32'(k == 2));
        end
        tick();
        ls_req_z = 1'b0;
        if_req_z = 1'b0;
        @(negedge clk);
        check("z_done_pulse", 32'(ls_done_z | if_done_z), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        // Reset state
        @(negedge clk);
        check("rst_addrbus", 32'(addrbus), 32'd0);
        check("rst_rw", 32'(rw), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_dones", 32'({if_done, ls_done}), 32'd0);
        check("rst_rdata", 32'({if_rdata, ls_rdata}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b0;

        // Load, store (ls_rdata must hold), fetch with address change mid-access
        access(1'b1, 1'b0, 16'h1234, 16'h1234, 8'h00, 8'hA5);
        access(1'b1, 1'b1, 16'h8001, 16'h8001, 8'h3C, 8'h77);
        access(1'b0, 1'b0, 16'h0010, 16'h0020, 8'h00, 8'h96);

        // Contention: last owner was IF, so order is LS, IF, LS, IF
        tick();
        din = 8'h5A;
        ls_we = 1'b0; ls_addr = 16'h2222; if_addr = 16'h1111;
        ls_req = 1'b1; if_req = 1'b1;
        ls_model = 8'h5A; if_model = 8'h5A;
        for (int g = 0; g < 4; g++) begin
            e.is_ls = (g % 2 == 0);
            e.addr  = e.is_ls ? 16'h2222 : 16'h1111;
            e.rdata = 8'h5A;
            sb.push_back(e);
        end
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check("arb_ls_done", 32'(ls_done), 32'(k == 3 || k == 11));
            check("arb_if_done", 32'(if_done), 32'(k == 7 || k == 15));
        end
        tick();
        ls_req = 1'b0;
        if_req = 1'b0;
        @(negedge clk);
        check("arb_idle", 32'(busy), 32'd0);

        // Async reset in the middle of a store, then re-grant of the held request
        tick();
        ls_we = 1'b1; ls_addr = 16'h4321; ls_wdata = 8'hE7; ls_req = 1'b1;
        tick();
        check("pre_rst_rw", 32'(rw), 32'd1);
        check("pre_rst_addr", 32'(addrbus), 32'h4321);
        #2 rst = 1'b1;
        #1;
        check("async_rw", 32'(rw), 32'd0);
        check("async_addr", 32'(addrbus), 32'd0);
        check("async_dout", 32'(dout), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("rst_no_done", 32'(ls_done | if_done), 32'd0);
        ls_model = 8'h00; if_model = 8'h00;
        tick();
        rst = 1'b0;
        e.is_ls = 1'b1; e.addr = 16'h4321; e.rdata = 8'h00;
        sb.push_back(e);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("regrant_busy", 32'(busy), 32'(k > 0));
            check("regrant_rw", 32'(rw), 32'(k == 1 || k == 2));
            if (k == 1) check("regrant_dout", 32'(dout), 32'hE7);
            check("regrant_done", 32'(ls_done), 32'(k == 3));
        end
        tick();
        ls_req = 1'b0;

        // Zero wait states: fetch at top of address space, then a load and a store
        access_z(1'b0, 1'b0, 16'hFFFF, 8'h00, 8'hC3);
        access_z(1'b1, 1'b0, 16'h0000, 8'h00, 8'h3D);
        access_z(1'b1, 1'b1, 16'h00FF, 8'h81, 8'h11);

        tick();
        check("sb_empty", 32'(sb.size()), 32'd0);
        check("sb_z_empty", 32'(sb_z.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/javk_bus_ctrl.md
Name: javk_bus_ctrl

Overview:
Bus sequencer and arbiter for the JAVK core's single external memory bus (16-bit addrbus, 8-bit databus, rw).
It serializes instruction-fetch (IF) and load/store (LS) requests from the core onto the bus. Each access gets a programmable number of wait states and a guaranteed turnaround cycle.
It sits between the core's fetch/ctrl logic and the top-level tri-state databus driver, replacing direct pc/IJ-driven addressing.

Parameters:
WAIT_STATES, 1, extra bus cycles per access beyond the first (legal 0..15)
ADDR_W, 16, address width
DATA_W, 8, data width

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
if_req  in  1  fetch request, level, held until if_done
if_addr  in  ADDR_W  fetch address, stable while if_req
if_done  out  1  one-cycle pulse, fetch complete, if_rdata valid
if_rdata  out  DATA_W  fetched byte, held until next IF completion
ls_req  in  1  load/store request, level, held until ls_done
ls_we  in  1  1 = store, 0 = load; stable while ls_req
ls_addr  in  ADDR_W  data address ({I,J}+offset from core)
ls_wdata  in  DATA_W  store data (register A)
ls_done  out  1  one-cycle pulse, LS complete
ls_rdata  out  DATA_W  loaded byte, held until next load completion
addrbus  out  ADDR_W  external address
rw  out  1  1 = write cycle, top level drives databus with dout
dout  out  DATA_W  write data to databus driver
din  in  DATA_W  databus read value
busy  out  1  state != IDLE

Behaviour:
- Reset (async, immediate): state IDLE, addrbus 0, rw 0, dout 0, if_done 0, ls_done 0, if_rdata 0, ls_rdata 0, cnt 0, owner IF, last_ls 0.
- Reset asserted mid-access aborts the access with no done pulse. Requesters must re-request after reset.
- All outputs are registered; no combinational path from req to bus pins.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - No req: stay, rw 0.
  - Any req: grant and latch owner, addr, we, wdata; load cnt with WAIT_STATES; go to ACCESS.
  - Arbitration when both reqs are high: LS wins unless last_ls=1, in which case IF wins (alternation under contention).
  - A single requester always wins.
- ACCESS:
  - addrbus = latched addr.
  - rw = 1 only for an LS store; IF is always read.
  - dout = latched wdata during a store, else unchanged.
  - cnt != 0: decrement, stay.
  - cnt == 0: go to RESP. For a read, capture din into the owner's rdata at this edge. Assert the owner's done.
- RESP:
  - Owner's done is high for exactly this cycle. rw 0 (bus turnaround); addrbus holds.
  - last_ls <= (owner == LS).
  - Next state is always IDLE; there is no back-to-back grant.
- Requester rule: req must be low in the cycle after done, otherwise IDLE treats it as a new request.
- Latency: req high in cycle N (controller IDLE) → ACCESS in cycles N+1..N+1+WAIT_STATES → done in cycle N+2+WAIT_STATES. Bus occupancy is WAIT_STATES+2 cycles per access.
- Requests arriving while busy wait in IDLE; none are dropped because reqs are level.
- Address and data are latched at grant. Changes to if_addr/ls_addr during an access are ignored.
- WAIT_STATES=0: ACCESS lasts 1 cycle; din is sampled at the end of that cycle.

Decomposition:
- Shared package javk_bus_pkg:
  - state encoding (IDLE=2'b00, ACCESS=2'b01, RESP=2'b10)
  - owner encoding (OWN_IF=0, OWN_LS=1)
  - default ADDR_W/DATA_W, WAIT_STATES maximum (15), cnt width 4
- One sub-module is natural: javk_bus_arb. It takes if_req, ls_req, last_ls and returns grant_valid and grant_owner. It is pure priority/alternation logic, testable on its own.
- The FSM, counter and latches live in javk_bus_ctrl.

Test Plan:
- WAIT_STATES=1, ls_req=1, ls_we=0, ls_addr=16'h1234, din=8'hA5 from cycle 2 → addrbus=16'h1234, rw=0 for 2 cycles; ls_done pulses in cycle 4 (req in cycle 1); ls_rdata=8'hA5.
- Store: ls_we=1, ls_addr=16'h8001, ls_wdata=8'h3C → rw=1 and dout=8'h3C for exactly WAIT_STATES+1 cycles; rw=0 in RESP; ls_done one cycle; ls_rdata unchanged.
- if_req and ls_req both held high, last_ls=0 after reset → grant order LS, IF, LS, IF. Each done is 1 cycle wide, with 3 cycles between grants when WAIT_STATES=1.
- Fetch at if_addr=16'hFFFF, WAIT_STATES=0 → single ACCESS cycle; if_done 2 cycles after req; if_rdata=din; no addr wrap side effects.
- rst asserted asynchronously in the middle of a store's ACCESS → rw, addrbus and dones go to 0 immediately, with no ls_done pulse. After rst deasserts, a held ls_req is re-granted from IDLE.
- if_req changes if_addr from 16'h0010 to 16'h0020 during ACCESS → addrbus stays 16'h0010 until RESP ends.
